// File: rtl/mod_ctrl.sv
// Controller side of the password handshake with mod_pass: menu, set/verify
// requests with ack timeout, unlocked playback with idle relock, and lockout.
module mod_ctrl #(
    parameter int unsigned ACK_CYC  = 1000,
    parameter int unsigned IDLE_CYC = 50000,
    parameter int unsigned CW       = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [4:1] key,
    input  logic [1:0] flag_pass,
    input  logic       keys_ena,
    input  logic       buzz_ena,
    output logic [2:1] f_pass,
    output logic       play_ena,
    output logic       pass_set,
    output logic [2:0] state,
    output logic       err,
    output logic       lock_led
);

    localparam int unsigned SW = 3;

    typedef enum logic [SW-1:0] {
        S_MENU    = 3'd0,
        S_SET_REQ = 3'd1,
        S_SET_RUN = 3'd2,
        S_VER_REQ = 3'd3,
        S_VER_RUN = 3'd4,
        S_OPEN    = 3'd5,
        S_LOCK    = 3'd6
    } state_t;

    state_t        state_q, state_d;
    logic [4:1]    key_q;
    logic [4:1]    kr;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          cnt_clr;
    logic          pass_set_d;
    logic          err_d;
    logic [2:1]    f_pass_d;
    logic          ack_to;
    logic          idle_to;

    assign kr      = key & ~key_q;
    assign ack_to  = (cnt_q == CW'(ACK_CYC - 1));
    assign idle_to = (cnt_q == CW'(IDLE_CYC - 1));
    assign state   = state_q;

    // Next-state, counter and output decode
    always_comb begin
        state_d    = state_q;
        cnt_clr    = 1'b0;
        pass_set_d = pass_set;
        err_d      = 1'b0;
        f_pass_d   = 2'b00;
        cnt_d      = cnt_q;

        case (state_q)
            S_MENU: begin
                if (kr[4]) begin
                    state_d = S_MENU;
                end else if (kr[1]) begin
                    state_d = S_SET_REQ;
                end else if (kr[2] && pass_set) begin
                    state_d = S_VER_REQ;
                end
            end
            S_SET_REQ: begin
                if (flag_pass == 2'b01) begin
                    state_d = S_SET_RUN;
                end else if (kr[4]) begin
                    state_d = S_MENU;
                end else if (ack_to) begin
                    state_d = S_MENU;
                    err_d   = 1'b1;
                end
            end
            S_SET_RUN: begin
                if (flag_pass == 2'b00) begin
                    state_d    = S_MENU;
                    pass_set_d = 1'b1;
                end else if (kr[4]) begin
                    state_d = S_MENU;
                end
            end
            S_VER_REQ: begin
                if (flag_pass == 2'b10) begin
                    state_d = S_VER_RUN;
                end else if (kr[4]) begin
                    state_d = S_MENU;
                end else if (ack_to) begin
                    state_d = S_MENU;
                    err_d   = 1'b1;
                end
            end
            S_VER_RUN: begin
                // Lockout report from mod_pass beats a user abort
                if (!keys_ena) begin
                    state_d = S_LOCK;
                end else if (flag_pass == 2'b00) begin
                    state_d = S_OPEN;
                end else if (kr[4]) begin
                    state_d = S_MENU;
                end
            end
            S_OPEN: begin
                if (kr[4]) begin
                    state_d = S_MENU;
                end else if (|kr[3:1]) begin
                    cnt_clr = 1'b1;
                end else if (idle_to) begin
                    state_d = S_MENU;
                end
            end
            S_LOCK: begin
                if (kr[4]) begin
                    state_d = S_MENU;
                end
            end
            default: state_d = S_MENU;
        endcase

        // Shared timeout counter: restarts on any state change, saturates
        if ((state_d != state_q) || cnt_clr) begin
            cnt_d = '0;
        end else if (((state_q == S_SET_REQ) || (state_q == S_VER_REQ) ||
                      (state_q == S_OPEN)) && (cnt_q != {CW{1'b1}})) begin
            cnt_d = cnt_q + CW'(1);
        end

        case (state_d)
            S_SET_REQ, S_SET_RUN: f_pass_d = 2'b01;
            S_VER_REQ, S_VER_RUN: f_pass_d = 2'b10;
            default:              f_pass_d = 2'b00;
        endcase
    end

    // State and registered outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_MENU;
            key_q    <= '0;
            cnt_q    <= '0;
            f_pass   <= 2'b00;
            play_ena <= 1'b0;
            pass_set <= 1'b0;
            err      <= 1'b0;
            lock_led <= 1'b0;
        end else begin
            state_q  <= state_d;
            key_q    <= key;
            cnt_q    <= cnt_d;
            f_pass   <= f_pass_d;
            play_ena <= (state_d == S_OPEN);
            pass_set <= pass_set_d;
            err      <= err_d;
            lock_led <= (state_d == S_LOCK) && buzz_ena;
        end
    end

endmodule

// File: tb/tb_mod_ctrl.sv
// Directed bench for mod_ctrl: the bench plays the mod_pass side by hand and
// checks state/outputs against hand-computed cycle timing.
module tb_mod_ctrl;

    localparam int unsigned ACK_CYC  = 1000;
    localparam int unsigned IDLE_CYC = 50000;

    logic       clk = 1'b0;
    logic       rst;
    logic [4:1] key;
    logic [1:0] flag_pass;
    logic       keys_ena;
    logic       buzz_ena;
    logic [2:1] f_pass;
    logic       play_ena;
    logic       pass_set;
    logic [2:0] state;
    logic       err;
    logic       lock_led;

    int n_tests = 0;
    int n_fail  = 0;

    mod_ctrl #(
        .ACK_CYC (ACK_CYC),
        .IDLE_CYC(IDLE_CYC),
        .CW      (16)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .key      (key),
        .flag_pass(flag_pass),
        .keys_ena (keys_ena),
        .buzz_ena (buzz_ena),
        .f_pass   (f_pass),
        .play_ena (play_ena),
        .pass_set (pass_set),
        .state    (state),
        .err      (err),
        .lock_led (lock_led)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Hold keys for exactly one sampled edge
    task automatic press(input logic [4:1] v);
        key = v;
        tick();
        key = '0;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_state"},    32'(state),    32'd0);
        check({tag, "_f_pass"},   32'(f_pass),   32'd0);
        check({tag, "_play"},     32'(play_ena), 32'd0);
        check({tag, "_pass_set"}, 32'(pass_set), 32'd0);
        check({tag, "_err"},      32'(err),      32'd0);
        check({tag, "_lock_led"}, 32'(lock_led), 32'd0);
    endtask

    initial begin
        rst       = 1'b1;
        key       = '0;
        flag_pass = 2'b00;
        keys_ena  = 1'b1;
        buzz_ena  = 1'b0;
        tick();
        tick();
        check_reset_outputs("rst");
        rst = 1'b0;
        tick();

        // 1: verify without stored password stays in MENU
        press(4'b0010);
        check("t1_state", 32'(state), 32'd0);
        check("t1_f_pass", 32'(f_pass), 32'd0);
        check("t1_err", 32'(err), 32'd0);
        tick();

        // 2: set handshake, echo after 5 cycles, done after 20 more
        press(4'b0001);
        check("t2_state_req", 32'(state), 32'd1);
        check("t2_f_pass_req", 32'(f_pass), 32'd1);
        repeat (4) tick();
        flag_pass = 2'b01;
        tick();
        check("t2_state_run", 32'(state), 32'd2);
        check("t2_f_pass_run", 32'(f_pass), 32'd1);
        repeat (19) tick();
        check("t2_still_run", 32'(state), 32'd2);
        check("t2_pass_set_pre", 32'(pass_set), 32'd0);
        flag_pass = 2'b00;
        tick();
        check("t2_state_done", 32'(state), 32'd0);
        check("t2_pass_set", 32'(pass_set), 32'd1);
        check("t2_f_pass_done", 32'(f_pass), 32'd0);
        tick();

        // 3: verify handshake opens playback, then idle relock
        press(4'b0010);
        check("t3_state_req", 32'(state), 32'd3);
        check("t3_f_pass_req", 32'(f_pass), 32'd2);
        flag_pass = 2'b10;
        tick();
        check("t3_state_run", 32'(state), 32'd4);
        repeat (2) tick();
        check("t3_play_pre", 32'(play_ena), 32'd0);
        flag_pass = 2'b00;
        tick();
        check("t3_state_open", 32'(state), 32'd5);
        check("t3_play", 32'(play_ena), 32'd1);
        check("t3_f_pass_open", 32'(f_pass), 32'd0);
        repeat (100) tick();
        press(4'b0100);
        check("t3_key3_stays", 32'(state), 32'd5);
        repeat (IDLE_CYC - 1) tick();
        check("t3_idle_edge", 32'(state), 32'd5);
        tick();
        check("t3_relock_state", 32'(state), 32'd0);
        check("t3_relock_play", 32'(play_ena), 32'd0);
        check("t3_relock_err", 32'(err), 32'd0);
        tick();

        // 4: set request without echo times out
        press(4'b0001);
        check("t4_state_req", 32'(state), 32'd1);
        repeat (ACK_CYC - 1) tick();
        check("t4_state_pre", 32'(state), 32'd1);
        check("t4_err_pre", 32'(err), 32'd0);
        tick();
        check("t4_err", 32'(err), 32'd1);
        check("t4_state", 32'(state), 32'd0);
        check("t4_f_pass", 32'(f_pass), 32'd0);
        tick();
        check("t4_err_pulse", 32'(err), 32'd0);

        // 5: lockout overrides abort; only key[4] leaves LOCK
        press(4'b0010);
        flag_pass = 2'b10;
        tick();
        check("t5_state_run", 32'(state), 32'd4);
        keys_ena = 1'b0;
        buzz_ena = 1'b1;
        press(4'b1000);
        check("t5_state_lock", 32'(state), 32'd6);
        check("t5_lock_led", 32'(lock_led), 32'd1);
        check("t5_f_pass", 32'(f_pass), 32'd0);
        check("t5_play", 32'(play_ena), 32'd0);
        flag_pass = 2'b00;
        tick();
        press(4'b0001);
        check("t5_key1_ignored", 32'(state), 32'd6);
        buzz_ena = 1'b0;
        tick();
        check("t5_lock_led_off", 32'(lock_led), 32'd0);
        press(4'b1000);
        check("t5_exit", 32'(state), 32'd0);
        check("t5_exit_led", 32'(lock_led), 32'd0);
        keys_ena = 1'b1;
        tick();

        // 6: key[4] beats key[1]; reset mid-handshake clears everything
        press(4'b1001);
        check("t6_prio_state", 32'(state), 32'd0);
        check("t6_prio_f_pass", 32'(f_pass), 32'd0);
        tick();
        press(4'b0001);
        flag_pass = 2'b01;
        tick();
        check("t6_state_run", 32'(state), 32'd2);
        rst = 1'b1;
        tick();
        check_reset_outputs("t6_rst");
        rst       = 1'b0;
        flag_pass = 2'b00;
        tick();
        press(4'b0010);
        check("t6_no_pass_verify", 32'(state), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
